// File: rtl/de0_nano_irq_aggregator.sv
// Avalon-MM interrupt aggregator: per-source level/edge pending, mask, priority encode to one CPU irq.
// Define IRQ_AGG_SYNC_EN to pass irq_in through a 2-flop synchronizer before use.
module de0_nano_irq_aggregator #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               chipselect,
   input  logic [2:0]         address,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   input  logic [NUM_SRC-1:0] irq_in,
   output logic [15:0]        readdata,
   output logic               irq,
   output logic [ID_W-1:0]    irq_id
);

   function automatic logic [NUM_SRC-1:0] trim_src(input logic [15:0] v);
      logic [NUM_SRC-1:0] r;
      for (int i = 0; i < NUM_SRC; i++) begin
         r[i] = v[i];
      end
      return r;
   endfunction

   function automatic logic [15:0] ext16(input logic [NUM_SRC-1:0] v);
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < NUM_SRC; i++) begin
         r[i] = v[i];
      end
      return r;
   endfunction

   function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
      logic [ID_W-1:0] r;
      r = {ID_W{1'b0}};
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = ID_W'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   logic [NUM_SRC-1:0] src_s;
   logic [NUM_SRC-1:0] irq_prev_r;
   logic [NUM_SRC-1:0] mask_r;
   logic [NUM_SRC-1:0] edge_r;
   logic               ctrl_r;
   logic [NUM_SRC-1:0] sticky_r;

   logic               wr_s;
   logic [NUM_SRC-1:0] wdata_s;
   logic               wr_pend_s, wr_mask_s, wr_edge_s, wr_ctrl_s, wr_swset_s;
   logic [NUM_SRC-1:0] rise_s, set_s, clr_s, chg_s, sticky_nxt_s;
   logic [NUM_SRC-1:0] pending_s, active_s;
   logic [ID_W-1:0]    winner_s;
   logic [15:0]        rdata_s;

`ifdef IRQ_AGG_SYNC_EN
   logic [NUM_SRC-1:0] sync1_r, sync2_r;

   // Two-stage synchronizer for asynchronous interrupt sources
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= {NUM_SRC{1'b0}};
         sync2_r <= {NUM_SRC{1'b0}};
      end else begin
         sync1_r <= irq_in;
         sync2_r <= sync1_r;
      end
   end

   assign src_s = sync2_r;
`else
   assign src_s = irq_in;
`endif

   // Write decode, sticky-bit next state, pending/priority and read mux
   always_comb begin
      wr_s       = chipselect & ~write_n;
      wdata_s    = trim_src(writedata);
      wr_pend_s  = wr_s & (address == 3'd0);
      wr_mask_s  = wr_s & (address == 3'd1);
      wr_edge_s  = wr_s & (address == 3'd2);
      wr_ctrl_s  = wr_s & (address == 3'd4);
      wr_swset_s = wr_s & (address == 3'd5);

      rise_s = src_s & ~irq_prev_r;
      set_s  = edge_r & (rise_s | (wr_swset_s ? wdata_s : {NUM_SRC{1'b0}}));
      clr_s  = wr_pend_s ? (wdata_s & edge_r) : {NUM_SRC{1'b0}};
      // A mode change discards stale sticky state, overriding any same-cycle set
      chg_s  = wr_edge_s ? (wdata_s ^ edge_r) : {NUM_SRC{1'b0}};
      sticky_nxt_s = ((sticky_r & ~clr_s) | set_s) & ~chg_s;

      pending_s = (sticky_r & edge_r) | (src_s & ~edge_r);
      active_s  = pending_s & mask_r;
      winner_s  = lowest_idx(active_s);

      rdata_s = 16'h0000;
      case (address)
         3'd0: rdata_s = ext16(pending_s);
         3'd1: rdata_s = ext16(mask_r);
         3'd2: rdata_s = ext16(edge_r);
         3'd3: begin
            rdata_s[15]       = |active_s;
            rdata_s[ID_W-1:0] = winner_s;
         end
         3'd4: rdata_s = {15'h0000, ctrl_r};
         default: rdata_s = 16'h0000;
      endcase
   end

   // Configuration, sticky pending and edge-history state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_prev_r <= {NUM_SRC{1'b0}};
         mask_r     <= {NUM_SRC{1'b0}};
         edge_r     <= {NUM_SRC{1'b0}};
         ctrl_r     <= 1'b0;
         sticky_r   <= {NUM_SRC{1'b0}};
      end else begin
         irq_prev_r <= src_s;
         sticky_r   <= sticky_nxt_s;
         if (wr_mask_s) begin
            mask_r <= wdata_s;
         end
         if (wr_edge_s) begin
            edge_r <= wdata_s;
         end
         if (wr_ctrl_s) begin
            ctrl_r <= writedata[0];
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= 16'h0000;
         irq      <= 1'b0;
         irq_id   <= {ID_W{1'b0}};
      end else begin
         readdata <= rdata_s;
         irq      <= ctrl_r & (|active_s);
         irq_id   <= winner_s;
      end
   end

endmodule

// File: tb/tb_de0_nano_irq_aggregator.sv
// Randomized self-checking bench for de0_nano_irq_aggregator with a per-source behavioural model.
// Honours IRQ_AGG_SYNC_EN the same way as the design (two extra input cycles).
module tb_de0_nano_irq_aggregator;
   localparam int N = 8;
`ifdef IRQ_AGG_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          chipselect = 1'b0;
   logic [2:0]    address = 3'd0;
   logic          write_n = 1'b1;
   logic [15:0]   writedata = 16'h0000;
   logic [N-1:0]  irq_in = 8'h00;
   logic [15:0]   readdata;
   logic          irq;
   logic [3:0]    irq_id;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   // model state
   bit m_mask[N], m_edge[N], m_sticky[N], m_prev[N], m_s1[N], m_s2[N];
   bit m_ctrl;
   logic [15:0] cur_rd, nxt_rd;
   logic        cur_irq, nxt_irq;
   logic [3:0]  cur_id, nxt_id;

   de0_nano_irq_aggregator #(.NUM_SRC(N), .ID_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
      .write_n(write_n), .writedata(writedata), .irq_in(irq_in),
      .readdata(readdata), .irq(irq), .irq_id(irq_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model every cycle, on the falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("irq", {15'h0000, irq}, {15'h0000, cur_irq});
         check("irq_id", {12'h000, irq_id}, {12'h000, cur_id});
         check("readdata", readdata, cur_rd);
      end
   end

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_mask[i] = 1'b0; m_edge[i] = 1'b0; m_sticky[i] = 1'b0;
         m_prev[i] = 1'b0; m_s1[i] = 1'b0; m_s2[i] = 1'b0;
      end
      m_ctrl = 1'b0;
      cur_rd = 16'h0000; cur_irq = 1'b0; cur_id = 4'h0;
      nxt_rd = 16'h0000; nxt_irq = 1'b0; nxt_id = 4'h0;
   endtask

   // Predict the next clock edge from the model state and the inputs now being driven
   task automatic model_step();
      bit src[N];
      bit wr, any, pend, rise, set, clr, chg;
      int win;
      logic [15:0] pv, mv, ev;
      wr = chipselect && !write_n;
      for (int i = 0; i < N; i++) src[i] = (LAT == 2) ? m_s2[i] : irq_in[i];
      pv = 16'h0000; mv = 16'h0000; ev = 16'h0000;
      any = 1'b0; win = 0;
      for (int i = 0; i < N; i++) begin
         pend = m_edge[i] ? m_sticky[i] : src[i];
         pv[i] = pend; mv[i] = m_mask[i]; ev[i] = m_edge[i];
         if (pend && m_mask[i] && !any) begin
            any = 1'b1;
            win = i;
         end
      end
      nxt_irq = m_ctrl && any;
      nxt_id  = 4'(win);
      case (address)
         3'd0: nxt_rd = pv;
         3'd1: nxt_rd = mv;
         3'd2: nxt_rd = ev;
         3'd3: nxt_rd = any ? (16'h8000 | 16'(win)) : 16'h0000;
         3'd4: nxt_rd = {15'h0000, m_ctrl};
         default: nxt_rd = 16'h0000;
      endcase
      for (int i = 0; i < N; i++) begin
         rise = src[i] && !m_prev[i];
         set  = m_edge[i] && (rise || (wr && address == 3'd5 && writedata[i]));
         clr  = m_edge[i] && wr && address == 3'd0 && writedata[i];
         chg  = wr && address == 3'd2 && (writedata[i] != m_edge[i]);
         if (chg) m_sticky[i] = 1'b0;
         else if (set) m_sticky[i] = 1'b1;
         else if (clr) m_sticky[i] = 1'b0;
         m_prev[i] = src[i];
         m_s2[i] = m_s1[i];
         m_s1[i] = irq_in[i];
         if (wr && address == 3'd1) m_mask[i] = writedata[i];
         if (wr && address == 3'd2) m_edge[i] = writedata[i];
      end
      if (wr && address == 3'd4) m_ctrl = writedata[0];
   endtask

   task automatic cyc(input logic c, input logic [2:0] a, input logic wn,
                      input logic [15:0] d, input logic [N-1:0] iv);
      @(posedge clk);
      #1;
      cur_rd = nxt_rd; cur_irq = nxt_irq; cur_id = nxt_id;
      chipselect = c; address = a; write_n = wn; writedata = d; irq_in = iv;
      model_step();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cyc(1'b1, a, 1'b0, d, irq_in);
   endtask

   task automatic rd(input logic [2:0] a);
      cyc(1'b0, a, 1'b1, 16'h0000, irq_in);
   endtask

   // Async reset asserted mid-cycle; outputs must clear before any clock edge
   task automatic do_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      chipselect = 1'b0; address = 3'd0; write_n = 1'b1; writedata = 16'h0000; irq_in = 8'h00;
      #1;
      check("rst_irq", {15'h0000, irq}, 16'h0000);
      check("rst_irq_id", {12'h000, irq_id}, 16'h0000);
      check("rst_readdata", readdata, 16'h0000);
      model_reset();
      model_step();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();
      chk_en = 1'b1;

      // Level source latency
      wr(3'd1, 16'h0001);
      wr(3'd4, 16'h0001);
      cyc(1'b0, 3'd3, 1'b1, 16'h0000, 8'h01);
      check("s1_pre", {15'h0000, irq}, 16'h0000);
      for (int j = 0; j < LAT; j++) begin
         rd(3'd3);
         check("s1_sync_wait", {15'h0000, irq}, 16'h0000);
      end
      rd(3'd3);
      check("s1_irq", {15'h0000, irq}, 16'h0001);
      check("s1_id", {12'h000, irq_id}, 16'h0000);
      check("s1_active", readdata, 16'h8000);
      cyc(1'b0, 3'd3, 1'b1, 16'h0000, 8'h00);
      for (int j = 0; j < LAT; j++) rd(3'd3);
      rd(3'd3);
      check("s1_drop", {15'h0000, irq}, 16'h0000);

      // Edge sticky and W1C
      do_reset();
      wr(3'd2, 16'h0004);
      wr(3'd1, 16'h0004);
      wr(3'd4, 16'h0001);
      cyc(1'b0, 3'd0, 1'b1, 16'h0000, 8'h04);
      cyc(1'b0, 3'd0, 1'b1, 16'h0000, 8'h00);
      for (int j = 0; j < 3 + LAT; j++) rd(3'd0);
      check("s2_pending", readdata, 16'h0004);
      check("s2_irq", {15'h0000, irq}, 16'h0001);
      wr(3'd0, 16'h0004);
      rd(3'd0);
      rd(3'd0);
      check("s2_cleared", readdata, 16'h0000);
      check("s2_irq_off", {15'h0000, irq}, 16'h0000);

      // Priority and masking
      do_reset();
      wr(3'd1, 16'h00FF);
      wr(3'd4, 16'h0001);
      cyc(1'b0, 3'd3, 1'b1, 16'h0000, 8'h28);
      for (int j = 0; j < 1 + LAT; j++) rd(3'd3);
      check("s3_id3", {12'h000, irq_id}, 16'h0003);
      check("s3_active3", readdata, 16'h8003);
      cyc(1'b0, 3'd3, 1'b1, 16'h0000, 8'h20);
      for (int j = 0; j < 1 + LAT; j++) rd(3'd3);
      check("s3_id5", {12'h000, irq_id}, 16'h0005);
      wr(3'd1, 16'h00DF);
      rd(3'd0);
      rd(3'd0);
      check("s3_masked_irq", {15'h0000, irq}, 16'h0000);
      check("s3_pending_kept", readdata, 16'h0020);

      // Set/clear collision: set wins
      do_reset();
      wr(3'd2, 16'h0002);
      cyc(1'b1, 3'd0, 1'b0, 16'h0002, 8'h02);
      for (int j = 0; j < 2 + LAT; j++) rd(3'd0);
      check("s4_collision", readdata, 16'h0002);

      // Software set, level bit unaffected, reserved address
      do_reset();
      wr(3'd2, 16'h0080);
      wr(3'd1, 16'h0080);
      wr(3'd4, 16'h0001);
      wr(3'd5, 16'h0081);
      rd(3'd0);
      rd(3'd6);
      check("s5_pending", readdata, 16'h0080);
      check("s5_irq", {15'h0000, irq}, 16'h0001);
      check("s5_id", {12'h000, irq_id}, 16'h0007);
      rd(3'd6);
      check("s5_reserved", readdata, 16'h0000);

      // Async reset with irq asserted, then configuration is gone
      do_reset();
      rd(3'd1);
      rd(3'd1);
      check("s6_mask_after_rst", readdata, 16'h0000);

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         logic [N-1:0] flip;
         flip = 8'($urandom) & 8'($urandom) & 8'($urandom);
         if (k == 1500) begin
            do_reset();
         end else begin
            cyc(1'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), irq_in ^ flip);
         end
      end
      rd(3'd0);
      rd(3'd0);
      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
